// File: rtl/cart_mapper.sv
// rtl/cart_mapper.sv - cartridge mapper: image loader, banked ROM, optional SRAM.
// Optional SRAM at 0x6000-0x7FFF is compiled in with macro CART_MAPPER_SRAM_EN.
module cart_mapper #(
  parameter int ROM_AW = 17,
  parameter int RAM_AW = 13,
  parameter int BANK_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_init_start,
  input  logic [7:0]        i_init_data,
  input  logic              i_init_valid,
  output logic              o_init_ready,
  input  logic              i_init_end,
  output logic              o_loaded,
  input  logic [4:0]        i_cfg_aw,
  input  logic              i_cfg_banked,
  input  logic              i_cfg_ram,
  input  logic              i_bank_we,
  input  logic [BANK_W-1:0] i_bank_d,
  input  logic [14:0]       i_a,
  input  logic [7:0]        i_db_i,
  output logic [7:0]        o_db_o,
  input  logic              i_ncs,
  input  logic              i_nrd,
  input  logic              i_nwr
);

  localparam int EXT_W = (ROM_AW > BANK_W + 15) ? ROM_AW : BANK_W + 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ROM_AW-1:0]   r_cnt;
  logic [BANK_W-1:0]   r_bank;
  logic [7:0]          r_db_o;
  logic [7:0]          r_rom [0:(2**ROM_AW)-1];

  logic                w_accept;
  logic                w_last;
  logic                w_cpu_rd;
  logic [EXT_W-1:0]    w_ext;
  logic [ROM_AW-1:0]   w_mask;
  logic [ROM_AW-1:0]   w_rom_addr;
  logic [7:0]          w_rd_data;
  logic                w_unused;

  // A byte offered together with INIT_START belongs to no image and is dropped.
  always_comb begin
    w_next_state = r_state;
    w_accept     = (r_state == S_LOAD) & i_init_valid & ~i_init_start & ~i_reset;
    w_last       = w_accept & (&r_cnt);
    if (i_reset) begin
      w_next_state = (r_state == S_RUN) ? S_RUN : S_IDLE;
    end else if (i_init_start) begin
      w_next_state = S_LOAD;
    end else if ((r_state == S_LOAD) && (i_init_end || w_last)) begin
      w_next_state = S_RUN;
    end
  end

  assign o_init_ready = (r_state == S_LOAD);
  assign o_loaded     = (r_state == S_RUN);
  assign o_db_o       = r_db_o;

  always_comb begin
    w_ext       = '0;
    w_ext[14:0] = i_a;
    if (i_cfg_banked) begin
      w_ext[BANK_W+14:15] = r_bank;
    end
  end

  // Shift amounts at or beyond ROM_AW leave the mask all ones.
  assign w_mask     = ~({ROM_AW{1'b1}} << i_cfg_aw);
  assign w_rom_addr = w_ext[ROM_AW-1:0] & w_mask;
  assign w_cpu_rd   = (r_state == S_RUN) & ~i_ncs & ~i_nrd;

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_rom[r_cnt] <= i_init_data;
    end
  end

`ifdef CART_MAPPER_SRAM_EN
  logic [7:0]        r_sram [0:(2**RAM_AW)-1];
  logic              w_sram_sel;
  logic              w_sram_wr;
  logic [RAM_AW-1:0] w_sram_addr;

  assign w_sram_sel  = i_cfg_ram & (i_a[14:13] == 2'b11);
  assign w_sram_addr = i_a[RAM_AW-1:0];
  assign w_sram_wr   = (r_state == S_RUN) & ~i_ncs & ~i_nwr & w_sram_sel & ~i_reset;

  // Non-blocking write gives read-before-write when nRD and nWR are both low.
  always_ff @(posedge i_clk) begin
    if (w_sram_wr) begin
      r_sram[w_sram_addr] <= i_db_i;
    end
  end

  assign w_rd_data = w_sram_sel ? r_sram[w_sram_addr] : r_rom[w_rom_addr];
  assign w_unused  = ^w_ext;
`else
  assign w_rd_data = r_rom[w_rom_addr];
  assign w_unused  = ^{w_ext, i_cfg_ram, i_db_i, i_nwr};
`endif

  always_ff @(posedge i_clk) begin
    r_state <= w_next_state;
    if (i_reset) begin
      r_cnt  <= '0;
      r_bank <= '0;
      r_db_o <= 8'hFF;
    end else begin
      if (i_init_start) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_bank_we) begin
        r_bank <= i_bank_d;
      end
      r_db_o <= w_cpu_rd ? w_rd_data : 8'hFF;
    end
  end

endmodule

// File: tb/tb_cart_mapper.sv
// tb/tb_cart_mapper.sv - directed self-checking bench for cart_mapper.
// Image byte at address a is a[7:0]^a[15:8]; SRAM checks follow CART_MAPPER_SRAM_EN.
module tb_cart_mapper;

  localparam int ROM_AW = 16;
  localparam int RAM_AW = 13;
  localparam int BANK_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_start, init_valid, init_end;
  logic [7:0]        init_data;
  logic              init_ready, loaded;
  logic [4:0]        cfg_aw;
  logic              cfg_banked, cfg_ram;
  logic              bank_we;
  logic [BANK_W-1:0] bank_d;
  logic [14:0]       a;
  logic [7:0]        db_i, db_o;
  logic              ncs, nrd, nwr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cart_mapper #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .BANK_W(BANK_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_init_start(init_start), .i_init_data(init_data),
    .i_init_valid(init_valid), .o_init_ready(init_ready), .i_init_end(init_end),
    .o_loaded(loaded), .i_cfg_aw(cfg_aw), .i_cfg_banked(cfg_banked), .i_cfg_ram(cfg_ram),
    .i_bank_we(bank_we), .i_bank_d(bank_d), .i_a(a), .i_db_i(db_i), .o_db_o(db_o),
    .i_ncs(ncs), .i_nrd(nrd), .i_nwr(nwr)
  );

  function automatic logic [7:0] img(input int addr);
    return addr[7:0] ^ addr[15:8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [14:0] addr);
    a = addr; ncs = 1'b0; nrd = 1'b0;
    tick();
    ncs = 1'b1; nrd = 1'b1;
  endtask

  task automatic wr(input logic [14:0] addr, input logic [7:0] d, input logic also_rd);
    a = addr; db_i = d; ncs = 1'b0; nwr = 1'b0; nrd = ~also_rd;
    tick();
    ncs = 1'b1; nwr = 1'b1; nrd = 1'b1;
  endtask

  task automatic start_load();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_start = 1'b0; init_valid = 1'b0; init_end = 1'b0; init_data = 8'h00;
    cfg_aw = 5'd15; cfg_banked = 1'b0; cfg_ram = 1'b0; bank_we = 1'b0; bank_d = '0;
    a = '0; db_i = 8'h00; ncs = 1'b1; nrd = 1'b1; nwr = 1'b1;
    tick(); tick();
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_ready", 32'(init_ready), 32'd0);
    check("rst_db_o", 32'(db_o), 32'hFF);
    rst = 1'b0;
    rd(15'h0010);
    check("idle_read", 32'(db_o), 32'hFF);

    // Small image; byte with INIT_START is dropped, last byte arrives with INIT_END.
    init_valid = 1'b1; init_data = 8'hEE;
    start_load();
    check("load_ready", 32'(init_ready), 32'd1);
    for (int k = 0; k < 256; k++) begin
      init_valid = 1'b1; init_data = img(k); init_end = (k == 255);
      tick();
    end
    init_valid = 1'b0; init_end = 1'b0;
    check("small_loaded", 32'(loaded), 32'd1);
    check("small_ready", 32'(init_ready), 32'd0);
    rd(15'h0010);
    check("rd_0010", 32'(db_o), 32'h10);
    rd(15'h0000);
    check("start_byte_dropped", 32'(db_o), 32'h00);
    rd(15'h00FE);
    check("rd_00fe", 32'(db_o), 32'hFE);
    a = 15'h0010; ncs = 1'b0; nrd = 1'b1;
    tick();
    ncs = 1'b1;
    check("nrd_high_ff", 32'(db_o), 32'hFF);

    // Reset aborts a load in progress.
    start_load();
    for (int k = 0; k < 100; k++) begin
      init_valid = 1'b1; init_data = img(k);
      tick();
    end
    init_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_loaded", 32'(loaded), 32'd0);
    check("abort_ready", 32'(init_ready), 32'd0);
    rd(15'h0010);
    check("abort_read_ff", 32'(db_o), 32'hFF);

    // Full image with no INIT_END.
    start_load();
    for (int k = 0; k < (1 << ROM_AW); k++) begin
      if (k == (1 << ROM_AW) - 1) begin
        check("prelast_ready", 32'(init_ready), 32'd1);
        check("prelast_loaded", 32'(loaded), 32'd0);
      end
      init_valid = 1'b1; init_data = img(k);
      tick();
    end
    init_valid = 1'b0;
    check("full_loaded", 32'(loaded), 32'd1);
    check("full_ready", 32'(init_ready), 32'd0);
    init_valid = 1'b1; init_data = 8'h33;
    tick();
    init_valid = 1'b0;
    check("extra_ready", 32'(init_ready), 32'd0);
    cfg_aw = 5'd16;
    rd(15'h0000);
    check("no_wrap_0000", 32'(db_o), 32'h00);
    rd(15'h7FFF);
    check("rd_7fff", 32'(db_o), 32'h80);

    // Banking: a write takes effect only for the following read.
    cfg_banked = 1'b1;
    bank_we = 1'b1; bank_d = 2'd1;
    rd(15'h0005);
    bank_we = 1'b0;
    check("bank_same_cycle", 32'(db_o), 32'h05);
    rd(15'h0005);
    check("bank1_0005", 32'(db_o), 32'h85);
    bank_we = 1'b1; bank_d = 2'd3;
    tick();
    bank_we = 1'b0;
    rd(15'h0005);
    check("bank3_aw16", 32'(db_o), 32'h85);
    cfg_aw = 5'd15;
    rd(15'h0005);
    check("bank3_aw15", 32'(db_o), 32'h05);

    // CPU writes.
    cfg_banked = 1'b0; cfg_aw = 5'd16; cfg_ram = 1'b1;
    wr(15'h0123, 8'h77, 1'b0);
    check("wr_only_ff", 32'(db_o), 32'hFF);
    rd(15'h0123);
    check("rom_unchanged", 32'(db_o), 32'h22);
`ifdef CART_MAPPER_SRAM_EN
    wr(15'h6123, 8'h5A, 1'b0);
    rd(15'h6123);
    check("sram_rd", 32'(db_o), 32'h5A);
    wr(15'h6123, 8'hA5, 1'b1);
    check("sram_rbw_old", 32'(db_o), 32'h5A);
    rd(15'h6123);
    check("sram_rbw_new", 32'(db_o), 32'hA5);
    cfg_ram = 1'b0;
    rd(15'h6123);
    check("sram_off_rom", 32'(db_o), 32'h42);
`else
    wr(15'h6123, 8'h5A, 1'b0);
    rd(15'h6123);
    check("no_sram_rom", 32'(db_o), 32'h42);
`endif

    // Reset in RUN keeps the image; reset outranks INIT_START.
    cfg_banked = 1'b1;
    rst = 1'b1; init_start = 1'b1;
    tick();
    rst = 1'b0; init_start = 1'b0;
    check("run_rst_loaded", 32'(loaded), 32'd1);
    check("run_rst_ready", 32'(init_ready), 32'd0);
    check("run_rst_db_o", 32'(db_o), 32'hFF);
    rd(15'h0005);
    check("run_rst_bank0", 32'(db_o), 32'h05);
    rd(15'h0010);
    check("run_rst_rom", 32'(db_o), 32'h10);
    check("run_rst_still", 32'(loaded), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cart_mapper.md
CART_MAPPER -- requirements
Module: cart_mapper

Interface
REQ-001 SHALL provide parameter ROM_AW, default 17, ROM image address width (max image 2^ROM_AW bytes).
REQ-002 SHALL provide parameter RAM_AW, default 13, cartridge SRAM address width.
REQ-003 SHALL provide parameter BANK_W, default 2, ROM bank register width.
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 INIT_START  in  1  one-cycle pulse; begins image load.
REQ-007 INIT_DATA  in  8  image byte.
REQ-008 INIT_VALID  in  1  INIT_DATA valid.
REQ-009 INIT_READY  out  1  mapper accepts a byte this cycle.
REQ-010 INIT_END  in  1  one-cycle pulse; image complete.
REQ-011 LOADED  out  1  valid image present (state RUN).
REQ-012 CFG_AW  in  5  effective ROM address width, 15..ROM_AW.
REQ-013 CFG_BANKED  in  1  1 = bank register extends ROM address.
REQ-014 CFG_RAM  in  1  1 = SRAM present at 0x6000-0x7FFF.
REQ-015 BANK_WE  in  1  bank register write strobe.
REQ-016 BANK_D  in  BANK_W  bank register data.
REQ-017 A  in  15  CPU cartridge address.
REQ-018 DB_I  in  8  CPU write data.
REQ-019 DB_O  out  8  CPU read data.
REQ-020 nCS, nRD, nWR  in  1 each  active-low select, read, write.

Function
REQ-021 SHALL implement states IDLE, LOAD, RUN; INIT_START in any state -> LOAD with load counter cleared to 0.
REQ-022 In LOAD, INIT_READY SHALL be 1; byte SHALL be accepted when INIT_VALID & INIT_READY, written at counter address, counter incremented by 1.
REQ-023 LOAD -> RUN on INIT_END, or on acceptance of the byte at address 2^ROM_AW-1; after that byte INIT_READY SHALL be 0 (no wrap-around).
REQ-024 INIT_END and a final accepted byte in the same cycle: byte SHALL be written, then RUN.
REQ-025 INIT_START and INIT_VALID in the same cycle: the byte SHALL be ignored; counter = 0.
REQ-026 INIT_READY SHALL be 0 in IDLE and RUN; LOADED = 1 only in RUN.
REQ-027 ROM address SHALL be ({bank, A} when CFG_BANKED else {0, A}) masked to CFG_AW bits, zero-extended to ROM_AW.
REQ-028 SRAM region = CFG_RAM & A[14:13]==2'b11; SRAM address = A[RAM_AW-1:0].
REQ-029 Read: DB_O SHALL update one cycle after a cycle with nCS=0, nRD=0 in RUN, with SRAM byte in SRAM region, else ROM byte.
REQ-030 DB_O SHALL be 0xFF one cycle after any cycle with nCS=1, nRD=1, or state not RUN.
REQ-031 Write: cycle with nCS=0, nWR=0, in RUN, in SRAM region SHALL write DB_I to SRAM; ROM writes SHALL be ignored.
REQ-032 nRD=0 and nWR=0 together: write SHALL occur; DB_O SHALL return the old SRAM byte (read-before-write).
REQ-033 BANK_WE=1 SHALL load BANK_D into the bank register at the next edge, affecting reads from the following cycle.

Reset
REQ-034 RESET SHALL set bank register = 0, DB_O = 0xFF, counter = 0.
REQ-035 RESET in LOAD SHALL abort to IDLE; RESET in RUN SHALL stay in RUN (cartridge survives console reset); RESET in IDLE stays IDLE.
REQ-036 RESET SHALL NOT clear ROM or SRAM contents; RESET has priority over INIT_START.

Configuration
REQ-037 Macro CART_MAPPER_SRAM_EN defined: SRAM array and REQ-028/031/032 compiled in.
REQ-038 Macro undefined: no SRAM storage; CFG_RAM ignored; 0x6000-0x7FFF reads ROM; all CPU writes ignored.

Verification
REQ-039 START, bytes 0x00..0xFF at addr 0..255, END; CFG_AW=15, read A=0x0010 -> DB_O=0x10 next cycle, LOADED=1.
REQ-040 Load 2^ROM_AW bytes without END -> RUN after last byte, INIT_READY=0, extra INIT_VALID ignored.
REQ-041 CFG_BANKED=1, BANK_D=2 written, read A=0x0005 -> byte from image address 0x10005.
REQ-042 CFG_RAM=1 (macro defined), write 0x5A at 0x6123, read 0x6123 -> 0x5A; write 0x77 at 0x0123 -> ROM unchanged.
REQ-043 RESET mid-load at byte 100 -> IDLE, reads 0xFF; RESET in RUN -> LOADED stays 1, bank=0, ROM intact.
